// File: rtl/stack_pkg.sv
// Shared encodings for the stack command sequencer: op codes, FSM state codes and
// default stack bounds.
package stack_pkg;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  localparam logic [15:0] EMPTY_SP_DEF = 16'hF000;
  localparam logic [15:0] FULL_SP_DEF  = 16'hE000;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_DEC  = 3'd1;
  localparam state_t ST_WR   = 3'd2;
  localparam state_t ST_RD   = 3'd3;
  localparam state_t ST_INC  = 3'd4;
  localparam state_t ST_LD   = 3'd5;
  localparam state_t ST_RESP = 3'd6;

endpackage

// File: rtl/stack_bounds_chk.sv
// Combinational stack bounds check: flags a PUSH into a full stack, a POP from an
// empty stack, or a LOAD of an SP value outside [FULL_SP, EMPTY_SP].
module stack_bounds_chk
  import stack_pkg::*;
#(
  parameter int unsigned   W        = 16,
  parameter logic [W-1:0]  EMPTY_SP = EMPTY_SP_DEF,
  parameter logic [W-1:0]  FULL_SP  = FULL_SP_DEF
) (
  input  logic [1:0]   op,
  input  logic [W-1:0] sp_val,
  input  logic [W-1:0] cmd_data,
  output logic         reject
);

  always_comb begin
    reject = 1'b0;
    case (op)
      OP_PUSH: reject = (sp_val <= FULL_SP);
      OP_POP:  reject = (sp_val >= EMPTY_SP);
      OP_LOAD: reject = (cmd_data < FULL_SP) || (cmd_data > EMPTY_SP);
      default: reject = 1'b0;
    endcase
  end

endmodule

// File: rtl/stack_ctrl.sv
// PUSH/POP/LOAD sequencer driving the SP register controls and the data-memory port.
// Define STACK_CTRL_BOUNDS_CHECK_EN to reject over/underflowing commands.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int unsigned   W        = 16,
  parameter logic [W-1:0]  EMPTY_SP = EMPTY_SP_DEF,
  parameter logic [W-1:0]  FULL_SP  = FULL_SP_DEF
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [W-1:0] cmd_data,
  output logic         resp_valid,
  output logic         resp_err,
  output logic [W-1:0] resp_data,
  output logic         sp_ld,
  output logic         sp_inc,
  output logic         sp_dec,
  output logic [W-1:0] sp_in,
  input  logic [W-1:0] sp_val,
  output logic [W-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  output logic         mem_we,
  output logic         mem_re,
  input  logic [W-1:0] mem_rdata,
  input  logic         mem_ack
);

  state_t       state_q, state_d;
  logic [1:0]   op_q, op_d;
  logic [W-1:0] data_q, data_d;
  logic [W-1:0] rdata_q, rdata_d;
  logic         err_q, err_d;
  logic         bounds_reject;

`ifdef STACK_CTRL_BOUNDS_CHECK_EN
  stack_bounds_chk #(
    .W        (W),
    .EMPTY_SP (EMPTY_SP),
    .FULL_SP  (FULL_SP)
  ) u_bounds (
    .op       (cmd_op),
    .sp_val   (sp_val),
    .cmd_data (cmd_data),
    .reject   (bounds_reject)
  );
`else
  assign bounds_reject = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          data_d = cmd_data;
          err_d  = 1'b0;
          // Rejected commands skip straight to the response with no side effects
          if (cmd_op == OP_RSVD || bounds_reject) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            case (cmd_op)
              OP_PUSH: state_d = ST_DEC;
              OP_POP:  state_d = ST_RD;
              default: state_d = ST_LD;
            endcase
          end
        end
      end
      ST_DEC:  state_d = ST_WR;
      ST_WR:   if (mem_ack) state_d = ST_RESP;
      ST_RD: begin
        if (mem_ack) begin
          rdata_d = mem_rdata;
          state_d = ST_INC;
        end
      end
      ST_INC:  state_d = ST_RESP;
      ST_LD:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode only registered state; sp_val is used unmodified as the address.
  always_comb begin
    cmd_ready  = (state_q == ST_IDLE);
    sp_dec     = (state_q == ST_DEC);
    sp_inc     = (state_q == ST_INC);
    sp_ld      = (state_q == ST_LD);
    sp_in      = (state_q == ST_LD) ? data_q : '0;
    mem_we     = (state_q == ST_WR);
    mem_re     = (state_q == ST_RD);
    mem_addr   = (state_q == ST_WR || state_q == ST_RD) ? sp_val : '0;
    mem_wdata  = (state_q == ST_WR) ? data_q : '0;
    resp_valid = (state_q == ST_RESP);
    resp_err   = (state_q == ST_RESP) && err_q;
    resp_data  = (state_q == ST_RESP && op_q == OP_POP && !err_q) ? rdata_q : '0;
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a behavioural SP register and a memory with
// configurable ack delay. Build with STACK_CTRL_BOUNDS_CHECK_EN for the bounded variant.
module tb_stack_ctrl;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        resp_valid;
  logic        resp_err;
  logic [15:0] resp_data;
  logic        sp_ld, sp_inc, sp_dec;
  logic [15:0] sp_in;
  logic [15:0] sp_val;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we, mem_re;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int failures = 0;

  stack_ctrl dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_data  (resp_data),
    .sp_ld      (sp_ld),
    .sp_inc     (sp_inc),
    .sp_dec     (sp_dec),
    .sp_in      (sp_in),
    .sp_val     (sp_val),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  // SP register model
  logic [15:0] sp_reg = 16'h0000;
  assign sp_val = sp_reg;
  always @(posedge clk) begin
    if (sp_ld)       sp_reg <= sp_in;
    else if (sp_inc) sp_reg <= sp_reg + 16'h1;
    else if (sp_dec) sp_reg <= sp_reg - 16'h1;
  end

  // Memory model: ack after ack_delay request cycles
  logic [15:0] mem [0:65535];
  int ack_delay = 0;
  int wait_cnt = 0;
  int dec_cnt = 0;
  int wr_cnt = 0;
  assign mem_ack   = (mem_we || mem_re) && (wait_cnt >= ack_delay);
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if ((mem_we || mem_re) && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                                wait_cnt <= 0;
    if (mem_we && mem_ack) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (sp_dec) dec_cnt <= dec_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one command for a single accept edge; returns in cycle 1
  task automatic send(input logic [1:0] op, input logic [15:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
  endtask

  int d0, w0;

  initial begin
    rst_b     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 16'h0;
    tick();
    tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_sp_dec", sp_dec, 0);
    chk("rst_sp_in", sp_in, 16'h0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    rst_b = 1'b0;
    tick();

    // LOAD F000
    send(2'b10, 16'hF000);
    chk("ld_sp_ld", sp_ld, 1);
    chk("ld_sp_in", sp_in, 16'hF000);
    chk("ld_busy", cmd_ready, 0);
    tick();
    chk("ld_resp_valid", resp_valid, 1);
    chk("ld_resp_err", resp_err, 0);
    chk("ld_sp", sp_val, 16'hF000);
    tick();

    // PUSH ABCD, immediate ack
    ack_delay = 0;
    send(2'b00, 16'hABCD);
    chk("push_c1_sp_dec", sp_dec, 1);
    chk("push_c1_mem_we", mem_we, 0);
    tick();
    chk("push_c2_mem_we", mem_we, 1);
    chk("push_c2_addr", mem_addr, 16'hEFFF);
    chk("push_c2_wdata", mem_wdata, 16'hABCD);
    chk("push_c2_sp_dec", sp_dec, 0);
    tick();
    chk("push_c3_resp_valid", resp_valid, 1);
    chk("push_c3_resp_err", resp_err, 0);
    chk("push_c3_resp_data", resp_data, 16'h0);
    chk("push_mem", mem[16'hEFFF], 16'hABCD);
    tick();
    chk("push_idle", cmd_ready, 1);

    // POP with ack delayed 3 cycles
    ack_delay = 3;
    send(2'b01, 16'h0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pop_rd%0d_mem_re", i), mem_re, 1);
      chk($sformatf("pop_rd%0d_addr", i), mem_addr, 16'hEFFF);
      chk($sformatf("pop_rd%0d_mem_we", i), mem_we, 0);
      tick();
    end
    chk("pop_sp_inc", sp_inc, 1);
    chk("pop_inc_mem_re", mem_re, 0);
    tick();
    chk("pop_resp_valid", resp_valid, 1);
    chk("pop_resp_data", resp_data, 16'hABCD);
    chk("pop_resp_err", resp_err, 0);
    chk("pop_sp", sp_val, 16'hF000);
    tick();
    chk("pop_after_resp_data", resp_data, 16'h0);

    // Reset asserted mid-WR
    ack_delay = 5;
    send(2'b00, 16'h5555);
    tick();
    chk("rstmid_mem_we_before", mem_we, 1);
    rst_b = 1'b1;
    #1;
    chk("rstmid_mem_we", mem_we, 0);
    chk("rstmid_cmd_ready", cmd_ready, 1);
    chk("rstmid_sp_dec", sp_dec, 0);
    tick();
    chk("rstmid_no_pulse", {29'b0, sp_dec, sp_inc, sp_ld}, 0);
    rst_b = 1'b0;
    tick();
    chk("rstmid_sp", sp_val, 16'hEFFF);
    chk("rstmid_no_write", mem[16'hEFFF], 16'hABCD);

    // Reserved op
    ack_delay = 0;
    send(2'b11, 16'h7777);
    chk("rsvd_resp_valid", resp_valid, 1);
    chk("rsvd_resp_err", resp_err, 1);
    chk("rsvd_resp_data", resp_data, 16'h0);
    chk("rsvd_side_effects", {28'b0, mem_re, mem_we, sp_ld, sp_dec}, 0);
    tick();

    // cmd_valid held high through a busy PUSH
    d0 = dec_cnt;
    w0 = wr_cnt;
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_data  = 16'h2468;
    tick();
    chk("held_c1_ready", cmd_ready, 0);
    tick();
    chk("held_c2_ready", cmd_ready, 0);
    tick();
    chk("held_c3_resp_valid", resp_valid, 1);
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("held_dec_count", dec_cnt - d0, 1);
    chk("held_wr_count", wr_cnt - w0, 1);
    chk("held_sp", sp_val, 16'hEFFE);
    chk("held_mem", mem[16'hEFFE], 16'h2468);

`ifndef STACK_CTRL_BOUNDS_CHECK_EN
    // No bounds: PUSH at SP=0000 wraps to FFFF
    send(2'b10, 16'h0000);
    tick();
    tick();
    send(2'b00, 16'h1234);
    tick();
    chk("wrap_mem_we", mem_we, 1);
    chk("wrap_addr", mem_addr, 16'hFFFF);
    tick();
    chk("wrap_resp_valid", resp_valid, 1);
    chk("wrap_resp_err", resp_err, 0);
    tick();
    chk("wrap_mem", mem[16'hFFFF], 16'h1234);
`else
    // Bounds on: POP from empty and PUSH into full are rejected
    send(2'b10, 16'hF000);
    tick();
    tick();
    send(2'b01, 16'h0);
    chk("empty_pop_resp_valid", resp_valid, 1);
    chk("empty_pop_resp_err", resp_err, 1);
    chk("empty_pop_side", {30'b0, mem_re, sp_inc}, 0);
    tick();
    chk("empty_pop_sp", sp_val, 16'hF000);
    send(2'b10, 16'hE000);
    chk("load_e000_ok", sp_ld, 1);
    tick();
    tick();
    send(2'b00, 16'h9999);
    chk("full_push_resp_valid", resp_valid, 1);
    chk("full_push_resp_err", resp_err, 1);
    chk("full_push_sp_dec", sp_dec, 0);
    tick();
    chk("full_push_sp", sp_val, 16'hE000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Sequencer that turns PUSH/POP/LOAD stack commands into properly ordered control pulses for the 16-bit stack pointer register (SP) and read/write cycles on the data-memory port. It sits directly upstream of SP: it drives SP's ld/inc/dec/in and consumes SP's out as the stack address. The stack grows downward: PUSH pre-decrements SP then writes at the new SP; POP reads at SP then post-increments. Commands use a valid/ready handshake and results return on a one-cycle response strobe.

## Interface
- W, 16, data and address width; must equal the SP width
- EMPTY_SP, 16'hF000, SP value when the stack is empty
- FULL_SP, 16'hE000, lowest legal SP value (stack full)
- clk  in  1  clock, rising-edge
- rst_b  in  1  reset; asynchronous, active-high (1 = reset)
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  00 PUSH, 01 POP, 10 LOAD, 11 reserved
- cmd_data  in  W  push word (PUSH) or new SP value (LOAD)
- resp_valid  out  1  one-cycle completion strobe
- resp_err  out  1  qualified by resp_valid; command rejected
- resp_data  out  W  popped word for a POP; 0 otherwise
- sp_ld, sp_inc, sp_dec  out  1 each  SP control pulses; at most one high per cycle
- sp_in  out  W  SP load value
- sp_val  in  W  current SP output
- mem_addr  out  W  memory address
- mem_wdata  out  W  memory write data
- mem_we, mem_re  out  1 each  write/read request, held until ack
- mem_rdata  in  W  read data, valid with mem_ack
- mem_ack  in  1  transfer complete; may be high in the first request cycle

## Operation
- States: IDLE, DEC, WR, RD, INC, LD, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch op and data.
  - PUSH goes to DEC.
  - POP goes to RD.
  - LOAD goes to LD.
  - Reserved op or bounds violation goes to RESP with err set.
- DEC: sp_dec=1 for exactly one cycle, then WR.
- WR: mem_we=1, mem_addr=sp_val (the decremented SP), mem_wdata=latched data. Stay until mem_ack, then RESP.
- RD: mem_re=1, mem_addr=sp_val. Stay until mem_ack; latch mem_rdata on that edge, then INC.
- INC: sp_inc=1 for one cycle, then RESP.
- LD: sp_ld=1, sp_in=latched data, for one cycle, then RESP.
- RESP: resp_valid=1 for one cycle; resp_data=popped word for a successful POP, else 0. Then IDLE.
- A rejected command has no side effects: no sp_* pulse and no mem_* request.
- SP arithmetic belongs to SP. This block never computes addresses and uses sp_val as-is, so 16-bit wrap-around follows SP.
- mem_we and mem_re are never both high. sp_in=0 outside LD.

## Timing
- All outputs registered or decoded from the registered state only. No combinational path from a cmd_* input to any output.
- Reset value of every output is 0, except cmd_ready=1 (state IDLE). Latched op, data and read word reset to 0.
- Reset asserted mid-operation: the FSM is forced to IDLE immediately. An in-flight memory request is dropped and a pending SP pulse is not issued.
- PUSH latency, with ack in the first WR cycle: accept edge T0, DEC in cycle 1, WR in cycle 2, resp_valid in cycle 3. Each extra wait cycle adds 1.
- POP latency, with immediate ack: RD in cycle 1, INC in cycle 2, resp_valid in cycle 3.
- LOAD and error: resp_valid in cycle 2 and cycle 1 respectively.
- A new command can be accepted in the cycle after RESP.
- cmd_valid while busy is ignored until cmd_ready=1.

## Configuration
- STACK_CTRL_BOUNDS_CHECK_EN defined:
  - PUSH with sp_val <= FULL_SP (unsigned) is rejected.
  - POP with sp_val >= EMPTY_SP is rejected.
  - LOAD with cmd_data outside [FULL_SP, EMPTY_SP] is rejected.
  - The check is made on the IDLE accept cycle.
- Not defined: no bounds checks. Only the reserved op sets resp_err. PUSH/POP proceed regardless and SP wraps freely.

## Structure
- Shared package stack_pkg holds:
  - op encodings (OP_PUSH, OP_POP, OP_LOAD)
  - the state enum
  - default EMPTY_SP/FULL_SP constants
- One sub-module, stack_bounds_chk: combinational, takes op, sp_val and cmd_data and returns reject. It is instantiated only under STACK_CTRL_BOUNDS_CHECK_EN.

## Test plan
- Reset: rst_b=1 mid-WR with mem_we=1 -> next sample shows mem_we=0, cmd_ready=1, no sp_dec pulse.
- LOAD 16'hF000, then PUSH 16'hABCD with immediate ack -> sp_dec in cycle 1, write at 16'hEFFF with data ABCD in cycle 2, resp_valid=1 and resp_err=0 in cycle 3.
- POP after that PUSH, with mem_ack delayed 3 cycles -> mem_re held 4 cycles at EFFF, then sp_inc, then resp_data=16'hABCD; SP returns to F000.
- Macro on, SP=F000: POP -> resp_err=1 in cycle 1, no mem_re, no sp_inc. SP=E000: PUSH -> resp_err=1.
- Macro off, SP=16'h0000: PUSH 16'h1234 -> write at 16'hFFFF, resp_err=0.
- cmd_op=11 -> resp_err=1, resp_data=0. cmd_valid held during a busy PUSH -> only one command accepted.
